// File: rtl/matrix_morph_3x3.sv
// 3x3 grey-scale morphology (dilate = max, erode = min) over three row-aligned
// pixel streams, cross or square structuring element, packed multi-channel pixels.
module matrix_morph_3x3 #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CH        = 1,
    parameter int unsigned PIC_WIDTH = 250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [DATA_W*CH-1:0] din1,
    input  logic [DATA_W*CH-1:0] din2,
    input  logic [DATA_W*CH-1:0] din3,
    input  logic                 mode,
    input  logic                 shape,
    output logic [DATA_W*CH-1:0] dout,
    output logic                 valid_out,
    output logic                 eol_out
);

    localparam int unsigned PIX_W = DATA_W * CH;
    localparam int unsigned CNT_W = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIC_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_WIN  = CNT_W'(2);

    logic [CNT_W-1:0] cnt;
    logic             cfg_mode;
    logic             cfg_shape;
    logic [PIX_W-1:0] tap1 [3];
    logic [PIX_W-1:0] tap2 [3];
    logic [PIX_W-1:0] tap3 [3];
    logic             win_ok;
    logic             win_last;
    logic [PIX_W-1:0] res_c;
    logic [DATA_W-1:0] acc_c;

    function automatic logic [DATA_W-1:0] pick(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              ero);
        if (ero) return (a < b) ? a : b;
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] ch_of(input logic [PIX_W-1:0] p,
                                                input int unsigned      c);
        return p[c*DATA_W +: DATA_W];
    endfunction

    // Column counter, per-row config latch and the three row tap shifters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cfg_mode  <= 1'b0;
            cfg_shape <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                tap1[i] <= '0;
                tap2[i] <= '0;
                tap3[i] <= '0;
            end
        end else if (valid_in) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            if (cnt == '0) begin
                cfg_mode  <= mode;
                cfg_shape <= shape;
            end
            tap1[2] <= tap1[1];
            tap1[1] <= tap1[0];
            tap1[0] <= din1;
            tap2[2] <= tap2[1];
            tap2[1] <= tap2[0];
            tap2[0] <= din2;
            tap3[2] <= tap3[1];
            tap3[1] <= tap3[0];
            tap3[0] <= din3;
        end
    end

    // Per-channel max/min; tap index 1 is the centre column.
    always_comb begin
        res_c = '0;
        acc_c = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            acc_c = ch_of(tap2[1], c);
            acc_c = pick(acc_c, ch_of(tap2[0], c), cfg_mode);
            acc_c = pick(acc_c, ch_of(tap2[2], c), cfg_mode);
            acc_c = pick(acc_c, ch_of(tap1[1], c), cfg_mode);
            acc_c = pick(acc_c, ch_of(tap3[1], c), cfg_mode);
            if (cfg_shape) begin
                acc_c = pick(acc_c, ch_of(tap1[0], c), cfg_mode);
                acc_c = pick(acc_c, ch_of(tap1[2], c), cfg_mode);
                acc_c = pick(acc_c, ch_of(tap3[0], c), cfg_mode);
                acc_c = pick(acc_c, ch_of(tap3[2], c), cfg_mode);
            end
            res_c[c*DATA_W +: DATA_W] = acc_c;
        end
    end

    // Window flags and registered outputs; dout holds between windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_ok    <= 1'b0;
            win_last  <= 1'b0;
            dout      <= '0;
            valid_out <= 1'b0;
            eol_out   <= 1'b0;
        end else begin
            win_ok    <= valid_in && (cnt >= CNT_WIN);
            win_last  <= valid_in && (cnt == CNT_LAST);
            valid_out <= win_ok;
            eol_out   <= win_ok && win_last;
            if (win_ok) dout <= res_c;
        end
    end

endmodule

// File: tb/tb_matrix_morph_3x3.sv
// Directed, table-driven bench for matrix_morph_3x3 (3 channels, 5-pixel rows).
module tb_matrix_morph_3x3;

    localparam int unsigned PW = 24;

    typedef struct packed {
        logic [4:0][PW-1:0] d1;
        logic [4:0][PW-1:0] d2;
        logic [4:0][PW-1:0] d3;
        logic               mode;
        logic               shape;
        logic [2:0][PW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [PW-1:0] din1, din2, din3;
    logic          mode, shape;
    logic [PW-1:0] dout;
    logic          valid_out, eol_out;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [PW-1:0] q_d[$];
    logic          q_e[$];
    int            q_c[$];

    vec_t vecs[10];

    matrix_morph_3x3 #(.DATA_W(8), .CH(3), .PIC_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .din1(din1), .din2(din2), .din3(din3),
        .mode(mode), .shape(shape),
        .dout(dout), .valid_out(valid_out), .eol_out(eol_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            q_d.push_back(dout);
            q_e.push_back(eol_out);
            q_c.push_back(cyc);
        end
        if (eol_out) cmp("eol_without_valid", 32'(valid_out), 32'd1);
    end

    function automatic logic [PW-1:0] rep(input int v);
        return {3{8'(v)}};
    endfunction

    function automatic logic [4:0][PW-1:0] row(input int a0, input int a1, input int a2,
                                               input int a3, input int a4);
        logic [4:0][PW-1:0] r;
        r[0] = rep(a0); r[1] = rep(a1); r[2] = rep(a2); r[3] = rep(a3); r[4] = rep(a4);
        return r;
    endfunction

    function automatic logic [2:0][PW-1:0] ex3(input int a, input int b, input int c);
        logic [2:0][PW-1:0] r;
        r[0] = rep(a); r[1] = rep(b); r[2] = rep(c);
        return r;
    endfunction

    task automatic run_row(input vec_t v, input int gap, input int tail, input int flip_at,
                           output logic [4:0][31:0] be);
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1;
            din1  = v.d1[i];
            din2  = v.d2[i];
            din3  = v.d3[i];
            mode  = (i >= flip_at) ? ~v.mode : v.mode;
            shape = v.shape;
            @(posedge clk); #1;
            be[i] = 32'(cyc);
            valid_in = 1'b0;
            for (int g = 0; g < gap; g++) begin
                din1 = PW'($urandom); din2 = PW'($urandom); din3 = PW'($urandom);
                mode = ~mode;
                @(posedge clk); #1;
            end
        end
        for (int t = 0; t < tail; t++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_row(input logic [2:0][PW-1:0] exp, input logic [4:0][31:0] be,
                             input string tag, input bit last);
        logic [PW-1:0] d;
        logic          e;
        int            c;
        for (int k = 0; k < 3; k++) begin
            if (q_d.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL %s_out%0d: no valid_out pulse, expected dout %0h", tag, k, exp[k]);
            end else begin
                d = q_d.pop_front();
                e = q_e.pop_front();
                c = q_c.pop_front();
                cmp($sformatf("%s_dout%0d", tag, k), 32'(d), 32'(exp[k]));
                cmp($sformatf("%s_eol%0d", tag, k), 32'(e), (k == 2) ? 32'd1 : 32'd0);
                cmp($sformatf("%s_lat%0d", tag, k), 32'(c), be[k+2] + 32'd1);
            end
        end
        if (last) cmp({tag, "_extra_pulses"}, 32'(q_d.size()), 32'd0);
    endtask

    initial begin
        logic [4:0][31:0] be, be_a;
        vec_t v;
        int gap_rows[3];

        vecs[0] = '{d1: row(0,0,0,0,0), d2: row(0,0,200,0,0), d3: row(0,0,0,0,0),
                    mode: 1'b0, shape: 1'b0, exp: ex3(200,200,200)};
        vecs[1] = '{d1: row(50,50,50,50,50), d2: row(50,50,10,50,50), d3: row(50,50,50,50,50),
                    mode: 1'b1, shape: 1'b0, exp: ex3(10,10,10)};
        vecs[2] = vecs[1];
        vecs[2].d1[0] = rep(5);
        vecs[2].shape = 1'b1;
        vecs[2].exp   = ex3(5,10,10);
        vecs[3] = vecs[2];
        vecs[3].shape = 1'b0;
        vecs[3].exp   = ex3(10,10,10);
        vecs[4] = '{d1: row(0,0,0,0,0), d2: row(0,0,0,0,0), d3: row(0,0,0,0,99),
                    mode: 1'b0, shape: 1'b1, exp: ex3(0,0,99)};
        vecs[5] = vecs[4];
        vecs[5].shape = 1'b0;
        vecs[5].exp   = ex3(0,0,0);
        vecs[6] = '{d1: row(100,100,100,100,100), d2: row(100,100,100,100,100),
                    d3: row(100,100,100,100,100), mode: 1'b0, shape: 1'b1, exp: ex3(0,0,0)};
        vecs[6].d1[2] = 24'h6464FA;
        vecs[6].d3[2] = 24'h036464;
        for (int k = 0; k < 3; k++) vecs[6].exp[k] = 24'h6464FA;
        vecs[7] = vecs[6];
        vecs[7].mode = 1'b1;
        for (int k = 0; k < 3; k++) vecs[7].exp[k] = 24'h036464;
        vecs[8] = '{d1: row(0,0,0,0,0), d2: row(10,20,30,40,50), d3: row(0,90,0,0,0),
                    mode: 1'b0, shape: 1'b0, exp: ex3(90,40,50)};
        vecs[9] = '{d1: row(200,200,200,200,200), d2: row(200,200,200,200,200),
                    d3: row(200,200,200,200,200), mode: 1'b1, shape: 1'b1, exp: ex3(9,200,7)};
        vecs[9].d1[4] = rep(7);
        vecs[9].d3[0] = rep(9);

        rst_n = 1'b0; valid_in = 1'b0; din1 = '0; din2 = '0; din3 = '0;
        mode = 1'b0; shape = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_dout", 32'(dout), 32'd0);
        cmp("reset_valid_out", 32'(valid_out), 32'd0);
        cmp("reset_eol_out", 32'(eol_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous rows, one per table entry.
        for (int i = 0; i < 10; i++) begin
            run_row(vecs[i], 0, 4, 99, be);
            check_row(vecs[i].exp, be, $sformatf("vec%0d", i), 1'b1);
        end

        // Alternating valid_in with junk on the idle cycles.
        gap_rows[0] = 0; gap_rows[1] = 6; gap_rows[2] = 9;
        for (int i = 0; i < 3; i++) begin
            run_row(vecs[gap_rows[i]], 1, 4, 99, be);
            check_row(vecs[gap_rows[i]].exp, be, $sformatf("gap%0d", gap_rows[i]), 1'b1);
        end

        // Mode flipped mid-row 0, back-to-back into row 1.
        run_row(vecs[0], 0, 0, 2, be_a);
        v = vecs[0];
        v.mode = 1'b1;
        v.exp  = ex3(0,0,0);
        run_row(v, 0, 4, 99, be);
        check_row(vecs[0].exp, be_a, "flip_row0", 1'b0);
        check_row(v.exp, be, "flip_row1", 1'b1);

        // Reset asserted after the cnt=3 beat, then a fresh row.
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            din1 = vecs[0].d1[i]; din2 = vecs[0].d2[i]; din3 = vecs[0].d3[i];
            mode = 1'b0; shape = 1'b0;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        cmp("pre_reset_valid_out", 32'(valid_out), 32'd1);
        cmp("pre_reset_dout", 32'(dout), 32'(rep(200)));
        rst_n = 1'b0;
        #1;
        cmp("mid_reset_dout", 32'(dout), 32'd0);
        cmp("mid_reset_valid_out", 32'(valid_out), 32'd0);
        cmp("mid_reset_eol_out", 32'(eol_out), 32'd0);
        q_d.delete(); q_e.delete(); q_c.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_row(vecs[1], 0, 4, 99, be);
        check_row(vecs[1].exp, be, "after_reset", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
